// File: rtl/tap_defs_pkg.sv
// Shared TAP definitions: state encoding, opcodes, IR capture pattern.
package tap_defs_pkg;

  // IEEE 1149.1 recommended 4-bit state encoding
  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR        = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR        = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_TEST_IDLE    = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_t;

  localparam logic [2:0] OP_EXTEST  = 3'b000;
  localparam logic [2:0] OP_IDCODE  = 3'b001;
  localparam logic [2:0] OP_SAMPLE  = 3'b010;
  localparam logic [2:0] OP_INTEST  = 3'b011;
  localparam logic [2:0] OP_BYPASS  = 3'b111;

  // Low bits loaded in Capture-IR; upper bits are zero-filled
  localparam logic [1:0] IR_CAPTURE = 2'b01;

endpackage

// File: rtl/tap_fsm.sv
// 16-state TAP controller: state register plus decoded per-state strobes.
module tap_fsm
  import tap_defs_pkg::*;
(
  input  logic tck,
  input  logic trst_n,
  input  logic tms,
  output logic capture_dr,
  output logic shift_dr,
  output logic update_dr,
  output logic capture_ir,
  output logic shift_ir,
  output logic update_ir,
  output logic reset_active
);

  tap_state_t state, state_nxt;

  // State register, async return to Test-Logic-Reset
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) state <= TEST_LOGIC_RESET;
    else         state <= state_nxt;
  end

  // Next-state on TMS and one-hot strobes for the current state
  always_comb begin
    state_nxt    = state;
    capture_dr   = 1'b0;
    shift_dr     = 1'b0;
    update_dr    = 1'b0;
    capture_ir   = 1'b0;
    shift_ir     = 1'b0;
    update_ir    = 1'b0;
    reset_active = 1'b0;
    case (state)
      TEST_LOGIC_RESET: begin
        reset_active = 1'b1;
        state_nxt = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      end
      RUN_TEST_IDLE: state_nxt = tms ? SELECT_DR : RUN_TEST_IDLE;
      SELECT_DR:     state_nxt = tms ? SELECT_IR : CAPTURE_DR;
      CAPTURE_DR: begin
        capture_dr = 1'b1;
        state_nxt = tms ? EXIT1_DR : SHIFT_DR;
      end
      SHIFT_DR: begin
        shift_dr = 1'b1;
        state_nxt = tms ? EXIT1_DR : SHIFT_DR;
      end
      EXIT1_DR:      state_nxt = tms ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:      state_nxt = tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR:      state_nxt = tms ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR: begin
        update_dr = 1'b1;
        state_nxt = tms ? SELECT_DR : RUN_TEST_IDLE;
      end
      SELECT_IR:     state_nxt = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR: begin
        capture_ir = 1'b1;
        state_nxt = tms ? EXIT1_IR : SHIFT_IR;
      end
      SHIFT_IR: begin
        shift_ir = 1'b1;
        state_nxt = tms ? EXIT1_IR : SHIFT_IR;
      end
      EXIT1_IR:      state_nxt = tms ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:      state_nxt = tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR:      state_nxt = tms ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR: begin
        update_ir = 1'b1;
        state_nxt = tms ? SELECT_DR : RUN_TEST_IDLE;
      end
      default:       state_nxt = TEST_LOGIC_RESET;
    endcase
  end

endmodule

// File: rtl/jtag_tap_responder.sv
// Device-side JTAG TAP: IR, bypass, boundary-scan register, TDO driver.
// Optional IDCODE register enabled by defining TAP_IDCODE_EN.
module jtag_tap_responder
  import tap_defs_pkg::*;
#(
  parameter int          BSC_Reg_size = 14,
  parameter int          IR_size      = 3,
  parameter logic [31:0] IDCODE_VAL   = 32'h1
) (
  input  logic                    TCK,
  input  logic                    TRST_N,
  input  logic                    TMS,
  input  logic                    TDI,
  output logic                    TDO,
  output logic                    enableTDO,
  input  logic [BSC_Reg_size-1:0] bsr_pin_in,
  output logic [BSC_Reg_size-1:0] bsr_pin_out,
  output logic                    test_mode
);

`ifdef TAP_IDCODE_EN
  localparam logic [IR_size-1:0] IR_RST = IR_size'(OP_IDCODE);
`else
  localparam logic [IR_size-1:0] IR_RST = IR_size'(OP_BYPASS);
`endif

  logic capture_dr, shift_dr, update_dr;
  logic capture_ir, shift_ir, update_ir, reset_active;

  logic [IR_size-1:0]      ir, ir_shift;
  logic [BSC_Reg_size-1:0] bsr_shift;
  logic                    bypass_reg;
  logic                    sel_bsr;
  logic                    dr_lsb;

  tap_fsm u_fsm (
    .tck          (TCK),
    .trst_n       (TRST_N),
    .tms          (TMS),
    .capture_dr   (capture_dr),
    .shift_dr     (shift_dr),
    .update_dr    (update_dr),
    .capture_ir   (capture_ir),
    .shift_ir     (shift_ir),
    .update_ir    (update_ir),
    .reset_active (reset_active)
  );

  function automatic logic is_bsr_op(input logic [IR_size-1:0] op);
    return (op == IR_size'(OP_EXTEST)) || (op == IR_size'(OP_SAMPLE)) ||
           (op == IR_size'(OP_INTEST));
  endfunction

  function automatic logic is_test_op(input logic [IR_size-1:0] op);
    return (op == IR_size'(OP_EXTEST)) || (op == IR_size'(OP_INTEST));
  endfunction

  assign sel_bsr = is_bsr_op(ir);

`ifdef TAP_IDCODE_EN
  logic [31:0] idcode_shift;
`else
  // Parameter kept for interface compatibility with the IDCODE build
  logic unused_idcode;
  assign unused_idcode = ^IDCODE_VAL;
`endif

  // LSB of whichever data register the current instruction selects
  always_comb begin
    dr_lsb = bypass_reg;
    if (sel_bsr) dr_lsb = bsr_shift[0];
`ifdef TAP_IDCODE_EN
    else if (ir == IR_size'(OP_IDCODE)) dr_lsb = idcode_shift[0];
`endif
  end

  // Capture/shift stages, all clocked on rising TCK
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      ir_shift   <= '0;
      bsr_shift  <= '0;
      bypass_reg <= 1'b0;
`ifdef TAP_IDCODE_EN
      idcode_shift <= '0;
`endif
    end else begin
      if (capture_ir)    ir_shift <= IR_size'(IR_CAPTURE);
      else if (shift_ir) ir_shift <= {TDI, ir_shift[IR_size-1:1]};

      if (capture_dr) begin
        bsr_shift  <= bsr_pin_in;
        bypass_reg <= 1'b0;
`ifdef TAP_IDCODE_EN
        idcode_shift <= IDCODE_VAL;
`endif
      end else if (shift_dr) begin
        // Unselected bypass/IDCODE shifting is invisible; only BSR is gated
        if (sel_bsr) bsr_shift <= {TDI, bsr_shift[BSC_Reg_size-1:1]};
        bypass_reg <= TDI;
`ifdef TAP_IDCODE_EN
        idcode_shift <= {TDI, idcode_shift[31:1]};
`endif
      end
    end
  end

  // Update stages and TDO driver, all clocked on falling TCK
  always_ff @(negedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      ir          <= IR_RST;
      test_mode   <= 1'b0;
      bsr_pin_out <= '0;
      TDO         <= 1'b0;
      enableTDO   <= 1'b0;
    end else begin
      enableTDO <= shift_dr | shift_ir;
      TDO       <= shift_ir ? ir_shift[0] : (shift_dr ? dr_lsb : 1'b0);
      if (reset_active) begin
        ir        <= IR_RST;
        test_mode <= 1'b0;
      end else if (update_ir) begin
        ir        <= ir_shift;
        test_mode <= is_test_op(ir_shift);
      end
      if (update_dr && sel_bsr) bsr_pin_out <= bsr_shift;
    end
  end

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Directed bench for jtag_tap_responder; honours TAP_IDCODE_EN.
module tb_jtag_tap_responder;

  localparam int BSC = 14;

  logic           TCK = 1'b0;
  logic           TRST_N, TMS, TDI;
  logic           TDO, enableTDO, test_mode;
  logic [BSC-1:0] bsr_pin_in, bsr_pin_out;

  int checks = 0;
  int errors = 0;

  logic [31:0] d;
  logic [2:0]  c;

  jtag_tap_responder #(
    .BSC_Reg_size (BSC),
    .IR_size      (3),
    .IDCODE_VAL   (32'h1234_5001)
  ) dut (
    .TCK         (TCK),
    .TRST_N      (TRST_N),
    .TMS         (TMS),
    .TDI         (TDI),
    .TDO         (TDO),
    .enableTDO   (enableTDO),
    .bsr_pin_in  (bsr_pin_in),
    .bsr_pin_out (bsr_pin_out),
    .test_mode   (test_mode)
  );

  always #5 TCK = ~TCK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One TCK: drive TMS/TDI, then return just after the falling edge
  task automatic clk(input logic tms_v, input logic tdi_v);
    TMS = tms_v;
    TDI = tdi_v;
    @(posedge TCK);
    @(negedge TCK);
    #1;
  endtask

  // From Run-Test/Idle: full DR scan of n bits, back to Run-Test/Idle
  task automatic scan_dr(input int n, input logic [31:0] din, output logic [31:0] dout);
    dout = '0;
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
    clk(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      dout[i] = TDO;
      clk(i == n - 1, din[i]);
    end
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
  endtask

  // From Run-Test/Idle: load a 3-bit opcode, returning the captured IR bits
  task automatic load_ir(input logic [2:0] op, output logic [2:0] cap);
    clk(1'b1, 1'b0);
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
    clk(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cap[i] = TDO;
      clk(i == 2, op[i]);
    end
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    TRST_N = 1'b0;
    TMS = 1'b1;
    TDI = 1'b0;
    bsr_pin_in = 14'h2AAA;
    #2;
    chk("rst_tdo",  TDO, 0);
    chk("rst_en",   enableTDO, 0);
    chk("rst_bsr",  bsr_pin_out, 0);
    chk("rst_mode", test_mode, 0);
    @(negedge TCK);
    TRST_N = 1'b1;
    #1;
    clk(1'b0, 1'b0);

    // DR selected by the reset instruction
`ifdef TAP_IDCODE_EN
    scan_dr(32, 32'h0, d);
    chk("idcode", d, 32'h1234_5001);
`else
    scan_dr(4, 32'hB, d);
    chk("reset_bypass", d, 32'h6);
`endif

    // IR capture pattern, then bypass delays data by one TCK
    load_ir(3'b111, c);
    chk("ir_capture", c, 3'b001);
    scan_dr(8, 32'hA5, d);
    chk("bypass_a5", d, 32'h4A);
    chk("en_idle", enableTDO, 0);

    // SAMPLE/PRELOAD
    load_ir(3'b010, c);
    chk("sample_mode", test_mode, 0);
    scan_dr(BSC, 32'h1555, d);
    chk("sample_tdo", d, 32'h2AAA);
    chk("sample_upd", bsr_pin_out, 32'h1555);

    // EXTEST
    bsr_pin_in = 14'h0F0F;
    load_ir(3'b000, c);
    chk("extest_mode", test_mode, 1);
    scan_dr(BSC, 32'h1234, d);
    chk("extest_tdo", d, 32'h0F0F);
    chk("extest_upd", bsr_pin_out, 32'h1234);

    // Five TMS=1 from Shift-IR reaches Test-Logic-Reset
    clk(1'b1, 1'b0);
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
    clk(1'b0, 1'b0);
    chk("shir_en", enableTDO, 1);
    chk("shir_tdo", TDO, 1);
    repeat (5) clk(1'b1, 1'b0);
    chk("tlr_state", dut.u_fsm.state, 32'hF);
    chk("tlr_mode", test_mode, 0);
    chk("tlr_bsr_hold", bsr_pin_out, 32'h1234);

    // Pause-IR holds partial shift; Exit2 resumes without re-capture
    clk(1'b0, 1'b0);
    clk(1'b1, 1'b0);
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
    clk(1'b0, 1'b0);
    chk("pir_bit0", TDO, 1);
    clk(1'b0, 1'b1);
    chk("pir_bit1", TDO, 0);
    clk(1'b1, 1'b1);
    clk(1'b0, 1'b0);
    clk(1'b0, 1'b0);
    chk("pir_pause_en", enableTDO, 0);
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
    chk("pir_resume_en", enableTDO, 1);
    chk("pir_resume_tdo", TDO, 0);
    clk(1'b0, 1'b1);
    chk("pir_next_tdo", TDO, 1);
    clk(1'b1, 1'b1);
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
    chk("pir_bypass_mode", test_mode, 0);

    // TRST_N mid Shift-DR aborts the scan
    load_ir(3'b000, c);
    chk("ext2_mode", test_mode, 1);
    scan_dr(BSC, 32'h0ABC, d);
    chk("ext2_tdo", d, 32'h0F0F);
    chk("ext2_upd", bsr_pin_out, 32'h0ABC);
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
    clk(1'b0, 1'b0);
    repeat (3) clk(1'b0, 1'b1);
    chk("abort_pre_en", enableTDO, 1);
    #2;
    TRST_N = 1'b0;
    #1;
    chk("abort_tdo",   TDO, 0);
    chk("abort_en",    enableTDO, 0);
    chk("abort_bsr",   bsr_pin_out, 0);
    chk("abort_mode",  test_mode, 0);
    chk("abort_state", dut.u_fsm.state, 32'hF);
    @(negedge TCK);
    TRST_N = 1'b1;
    #1;
    clk(1'b0, 1'b0);
`ifdef TAP_IDCODE_EN
    scan_dr(4, 32'hB, d);
    chk("abort_ir_rst", d, 32'h1);
`else
    scan_dr(4, 32'hB, d);
    chk("abort_ir_rst", d, 32'h6);
`endif
    chk("abort_bsr_after", bsr_pin_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
